// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair.
// States: IDLE | accepting start and mthi/mtlo;  RUN | op in flight, commit when counter hits 1.
module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  MDop,
    input  logic        ifmsub,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic [1:0]  mf,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] md_out
);
    localparam int NMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(NMAX + 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic [31:0]   hi_q, lo_q, a_q, b_q;
    logic [1:0]    op_q;
    logic          msub_q;

    logic [31:0] hi_d, lo_d;
    logic [63:0] a_ext, b_ext, prod;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

    // op_q[1] selects signed handling for both multiply and divide
    assign a_ext = {{32{op_q[1] & a_q[31]}}, a_q};
    assign b_ext = {{32{op_q[1] & b_q[31]}}, b_q};
    assign prod  = a_ext * b_ext;

    // Signed divide runs on magnitudes; 0x80000000/-1 falls out as 0x80000000 rem 0
    assign a_neg = op_q[1] & a_q[31];
    assign b_neg = op_q[1] & b_q[31];
    assign a_mag = a_neg ? (32'd0 - a_q) : a_q;
    assign b_mag = b_neg ? (32'd0 - b_q) : b_q;
    assign q_mag = a_mag / b_mag;
    assign r_mag = a_mag % b_mag;
    assign quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (op_q[0]) begin
            if (b_q != 32'd0) begin
                hi_d = rem;
                lo_d = quot;
            end
        end else if (msub_q) begin
            {hi_d, lo_d} = {hi_q, lo_q} - prod;
        end else begin
            {hi_d, lo_d} = prod;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            msub_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        op_q    <= MDop;
                        msub_q  <= ifmsub & (MDop == 2'b10);
                        cnt_q   <= MDop[0] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        if (mthi) hi_q <= wdata;
                        if (mtlo) lo_q <= wdata;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign HI     = hi_q;
    assign LO     = lo_q;
    assign md_out = (mf == 2'b10) ? hi_q : (mf == 2'b01) ? lo_q : 32'd0;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic reference model checked every cycle plus literal result checks.
module tb_muldiv_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, ifmsub = 1'b0;
    logic [1:0]  MDop = 2'b00, mf = 2'b00;
    logic [31:0] A = '0, B = '0, wdata = '0;
    logic        mthi = 1'b0, mtlo = 1'b0;
    logic        busy;
    logic [31:0] HI, LO, md_out;

    muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .MDop(MDop), .ifmsub(ifmsub),
        .A(A), .B(B), .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .mf(mf),
        .busy(busy), .HI(HI), .LO(LO), .md_out(md_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: remaining busy cycles plus 64-bit arithmetic on commit
    logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
    logic [1:0]  m_op = '0;
    logic        m_sub = 1'b0;
    int          m_rem = 0;

    always @(posedge clk or negedge reset_n) begin
        logic [63:0] p, hl;
        longint sa, sb, q, r;
        if (!reset_n) begin
            m_hi = '0; m_lo = '0; m_rem = 0;
        end else if (m_rem == 0) begin
            if (start) begin
                m_a = A; m_b = B; m_op = MDop;
                m_sub = ifmsub && (MDop == 2'b10);
                m_rem = MDop[0] ? DC : MC;
            end else begin
                if (mthi) m_hi = wdata;
                if (mtlo) m_lo = wdata;
            end
        end else begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                sa = longint'($signed(m_a));
                sb = longint'($signed(m_b));
                case (m_op)
                    2'b00: begin p = {32'd0, m_a} * {32'd0, m_b}; {m_hi, m_lo} = p; end
                    2'b10: begin
                        p = sa * sb;
                        hl = {m_hi, m_lo};
                        if (m_sub) hl = hl - p; else hl = p;
                        {m_hi, m_lo} = hl;
                    end
                    2'b01: if (m_b != 0) begin m_lo = m_a / m_b; m_hi = m_a % m_b; end
                    default: if (m_b != 0) begin
                        q = sa / sb; r = sa % sb;
                        p = q; m_lo = p[31:0];
                        p = r; m_hi = p[31:0];
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] exp_md;
        exp_md = (mf == 2'b10) ? m_hi : (mf == 2'b01) ? m_lo : 32'd0;
        chk("cyc busy", {63'd0, busy}, {63'd0, m_rem != 0});
        chk("cyc HI", {32'd0, HI}, {32'd0, m_hi});
        chk("cyc LO", {32'd0, LO}, {32'd0, m_lo});
        chk("cyc md_out", {32'd0, md_out}, {32'd0, exp_md});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic sub);
        MDop = op; A = a; B = b; ifmsub = sub; start = 1'b1;
        cyc();
        start = 1'b0; ifmsub = 1'b0;
    endtask

    task automatic wait_idle(input int expn, input string nm);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            n++;
            cyc();
        end
        chk({nm, " busy cycles"}, 64'(n), 64'(expn));
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input int expn, input string nm);
        launch(op, a, b, sub);
        wait_idle(expn, nm);
    endtask

    task automatic lit(input string nm, input logic [31:0] hi_e, input logic [31:0] lo_e);
        chk({nm, " HI"}, {32'd0, HI}, {32'd0, hi_e});
        chk({nm, " LO"}, {32'd0, LO}, {32'd0, lo_e});
        chk({nm, " model HI"}, {32'd0, m_hi}, {32'd0, hi_e});
        chk({nm, " model LO"}, {32'd0, m_lo}, {32'd0, lo_e});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) cyc();
        reset_n = 1'b1;
        cyc();
        lit("reset", 32'h0, 32'h0);
        chk("reset busy", {63'd0, busy}, 64'd0);

        mf = 2'b01;
        run_op(2'b00, 32'hFFFFFFFF, 32'd2, 1'b0, MC, "multu");
        lit("multu", 32'h00000001, 32'hFFFFFFFE);

        run_op(2'b10, 32'hFFFFFFFD, 32'd4, 1'b0, MC, "mult");
        lit("mult", 32'hFFFFFFFF, 32'hFFFFFFF4);
        mf = 2'b10; #1 chk("mf=10", {32'd0, md_out}, 64'hFFFFFFFF);
        mf = 2'b01; #1 chk("mf=01", {32'd0, md_out}, 64'hFFFFFFF4);
        mf = 2'b00; #1 chk("mf=00", {32'd0, md_out}, 64'h0);
        mf = 2'b11; #1 chk("mf=11", {32'd0, md_out}, 64'h0);
        mf = 2'b10;

        run_op(2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, DC, "div");
        lit("div -7/2", 32'hFFFFFFFF, 32'hFFFFFFFD);

        run_op(2'b01, 32'd7, 32'd0, 1'b0, DC, "divu by zero");
        lit("divu by zero", 32'hFFFFFFFF, 32'hFFFFFFFD);

        mthi = 1'b1; wdata = 32'd0; cyc();
        mthi = 1'b0; mtlo = 1'b1; wdata = 32'd10; cyc();
        mtlo = 1'b0;
        lit("mthi/mtlo", 32'd0, 32'd10);
        run_op(2'b10, 32'd3, 32'd4, 1'b1, MC, "msub");
        lit("msub", 32'hFFFFFFFF, 32'hFFFFFFFE);

        run_op(2'b00, 32'd3, 32'd4, 1'b1, MC, "ifmsub on multu");
        lit("ifmsub on multu", 32'd0, 32'd12);

        // start and mtlo while busy must both be ignored
        launch(2'b00, 32'd3, 32'd5, 1'b0);
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            n++;
            if (n == 2) begin
                start = 1'b1; MDop = 2'b11; A = 32'd100; B = 32'd3; mtlo = 1'b1; wdata = 32'hDEAD;
            end else begin
                start = 1'b0; mtlo = 1'b0;
            end
            cyc();
        end
        start = 1'b0; mtlo = 1'b0;
        chk("busy-ignore busy cycles", 64'(n), 64'(MC));
        lit("busy-ignore", 32'd0, 32'd15);

        // start wins over a same-cycle mthi
        MDop = 2'b00; A = 32'd2; B = 32'd3; start = 1'b1; mthi = 1'b1; wdata = 32'hAAAA;
        cyc();
        start = 1'b0; mthi = 1'b0;
        wait_idle(MC, "start+mthi");
        lit("start+mthi", 32'd0, 32'd6);

        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h12345678; cyc();
        mthi = 1'b0; mtlo = 1'b0;
        lit("mthi+mtlo", 32'h12345678, 32'h12345678);

        // back-to-back: each launch lands in the first idle cycle
        run_op(2'b00, 32'h00010000, 32'h00010000, 1'b0, MC, "b2b multu");
        lit("b2b multu", 32'd1, 32'd0);
        run_op(2'b01, 32'd100, 32'd7, 1'b0, DC, "b2b divu");
        lit("b2b divu", 32'd2, 32'd14);
        run_op(2'b11, 32'd7, 32'hFFFFFFFE, 1'b0, DC, "div 7/-2");
        lit("div 7/-2", 32'd1, 32'hFFFFFFFD);
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, DC, "div overflow");
        lit("div overflow", 32'd0, 32'h80000000);

        run_op(2'b00, 32'd9, 32'd9, 1'b0, MC, "pre-reset");
        launch(2'b10, 32'd7, 32'd7, 1'b0);
        cyc(); cyc();
        reset_n = 1'b0;
        #1;
        chk("async reset busy", {63'd0, busy}, 64'd0);
        lit("async reset", 32'd0, 32'd0);
        cyc(); cyc();
        reset_n = 1'b1;
        repeat (12) cyc();
        chk("post-reset busy", {63'd0, busy}, 64'd0);
        lit("post-reset no commit", 32'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
